i_cache_sa: RTL and testbench

Parametrised set-associative instruction cache for the IFU. It serves core fetches with a one-cycle hit latency and runs a miss/refill state machine toward instruction memory with a ready/valid request handshake. Victims are chosen by per-set tree pseudo-LRU, and the block supports a whole-cache flush and hit/miss performance counters. It sits between the core fetch stage (Q100H request, Q101H response) and the i_mem.

---
 rtl/ifu_pkg.sv | 43 ++++
 rtl/i_cache_sa_if.sv | 36 +++
 rtl/i_cache_plru.sv | 46 ++++
 rtl/i_cache_sa.sv | 171 +++++++++++++++++
 tb/tb_i_cache_sa.sv | 349 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ifu_pkg.sv
`default_nettype none
// ============================================================================
// ifu_pkg : shared types and derived geometry for the IFU instruction cache
// Rev 1.0
// ============================================================================
package ifu_pkg;

    localparam int XLEN         = 32;
    localparam int DEF_WAYS_NUM = 4;
    localparam int DEF_SETS_NUM = 16;
    localparam int DEF_CL_WIDTH = 128;

    localparam int OFFSET_WIDTH = $clog2(DEF_CL_WIDTH / 8);
    localparam int INDEX_WIDTH  = $clog2(DEF_SETS_NUM);
    localparam int TAG_WIDTH    = XLEN - OFFSET_WIDTH - INDEX_WIDTH;
    localparam int PLRU_BITS    = DEF_WAYS_NUM - 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } t_i_cache_state;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
    } t_fetch_req;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] instruction;
    } t_fetch_rsp;

    function automatic int offset_width(input int cl_width);
        return $clog2(cl_width / 8);
    endfunction

    function automatic int index_width(input int sets_num);
        return $clog2(sets_num);
    endfunction

endpackage
`default_nettype wire

// File: rtl/i_cache_sa_if.sv
`default_nettype none
// ============================================================================
// i_cache_sa_if : core fetch, refill and counter signals of the instruction cache
// Rev 1.0
// ============================================================================
interface i_cache_sa_if #(
    parameter int CL_WIDTH  = 128,
    parameter int CNT_WIDTH = 32
);
    logic                 core_req_valid;
    logic [31:0]          pcQ100H;
    logic                 flush;
    logic                 cache2core_rsp_valid;
    logic [31:0]          cache2core_rsp_instruction;
    logic                 cache_stall;
    logic                 mem_req_valid;
    logic                 mem_req_ready;
    logic [31:0]          mem_req_addr;
    logic                 mem_rsp_valid;
    logic [CL_WIDTH-1:0]  mem_rsp_data;
    logic [CNT_WIDTH-1:0] hit_cnt;
    logic [CNT_WIDTH-1:0] miss_cnt;

    modport slave (
        input  core_req_valid, pcQ100H, flush, mem_req_ready, mem_rsp_valid, mem_rsp_data,
        output cache2core_rsp_valid, cache2core_rsp_instruction, cache_stall,
               mem_req_valid, mem_req_addr, hit_cnt, miss_cnt
    );

    modport master (
        output core_req_valid, pcQ100H, flush, mem_req_ready, mem_rsp_valid, mem_rsp_data,
        input  cache2core_rsp_valid, cache2core_rsp_instruction, cache_stall,
               mem_req_valid, mem_req_addr, hit_cnt, miss_cnt
    );
endinterface
`default_nettype wire

// File: rtl/i_cache_plru.sv
`default_nettype none
// ============================================================================
// i_cache_plru : combinational tree pseudo-LRU update and victim select for one set
// Rev 1.0
// ============================================================================
module i_cache_plru
    import ifu_pkg::*;
#(
    parameter  int WAYS_NUM = DEF_WAYS_NUM,
    localparam int WAY_W    = $clog2(WAYS_NUM),
    localparam int NBITS    = WAYS_NUM - 1
) (
    input  logic [NBITS-1:0] cur_bits,
    input  logic [WAY_W-1:0] access_way,
    input  logic             update_en,
    output logic [NBITS-1:0] next_bits,
    output logic [WAY_W-1:0] victim_way
);
    // Heap-ordered tree: node n has children 2n+1 / 2n+2; a bit points at the victim side.
    always_comb begin
        int   node;
        logic dir;
        next_bits  = cur_bits;
        victim_way = '0;
        node       = 0;
        for (int lvl = 0; lvl < WAY_W; lvl++) begin
            dir = 1'b0;
            for (int n = 0; n < NBITS; n++) begin
                if (n == node) dir = cur_bits[n];
            end
            victim_way[WAY_W-1-lvl] = dir;
            node = 2 * node + 1 + (dir ? 1 : 0);
        end
        if (update_en) begin
            node = 0;
            for (int lvl = 0; lvl < WAY_W; lvl++) begin
                dir = access_way[WAY_W-1-lvl];
                for (int n = 0; n < NBITS; n++) begin
                    if (n == node) next_bits[n] = ~dir;
                end
                node = 2 * node + 1 + (dir ? 1 : 0);
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/i_cache_sa.sv
`default_nettype none
// ============================================================================
// i_cache_sa : set-associative instruction cache, 1-cycle hit, PLRU refill FSM
// Rev 1.0
// ============================================================================
module i_cache_sa
    import ifu_pkg::*;
#(
    parameter int WAYS_NUM  = 4,
    parameter int SETS_NUM  = 16,
    parameter int CL_WIDTH  = 128,
    parameter int CNT_WIDTH = 32
) (
    input  logic        clk,
    input  logic        rst,
    i_cache_sa_if.slave bus
);
    localparam int OFF      = offset_width(CL_WIDTH);
    localparam int IDX_BITS = index_width(SETS_NUM);
    localparam int IDX_W    = (IDX_BITS > 0) ? IDX_BITS : 1;
    localparam int TAG_W    = XLEN - OFF - IDX_BITS;
    localparam int WORD_W   = OFF - 2;
    localparam int WAY_W    = $clog2(WAYS_NUM);
    localparam int PB       = WAYS_NUM - 1;
    localparam int LINE_W   = XLEN - OFF;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    t_i_cache_state state, state_next;
    t_fetch_req     req;
    t_fetch_rsp     rsp_q;

    logic [CL_WIDTH-1:0]  data_q  [SETS_NUM][WAYS_NUM];
    logic [TAG_W-1:0]     tag_q   [SETS_NUM][WAYS_NUM];
    logic [WAYS_NUM-1:0]  valid_q [SETS_NUM];
    logic [PB-1:0]        plru_q  [SETS_NUM];

    logic [LINE_W-1:0]    miss_line;
    logic [WORD_W-1:0]    miss_word;
    logic [CNT_WIDTH-1:0] hit_cnt_q, miss_cnt_q;

    logic [IDX_W-1:0]     req_idx, miss_idx, plru_set;
    logic [TAG_W-1:0]     req_tag, miss_tag;
    logic [WORD_W-1:0]    req_word;
    logic [WAYS_NUM-1:0]  hit_vec;
    logic [WAY_W-1:0]     hit_way, fill_way, plru_way, plru_victim;
    logic [PB-1:0]        plru_next;
    logic [CL_WIDTH-1:0]  hit_line;
    logic                 lookup, lookup_hit, lookup_miss, fill, plru_en;
    logic                 unused_pc_bits;

    assign req.valid = bus.core_req_valid;
    assign req.pc    = bus.pcQ100H;

    generate
        if (IDX_BITS > 0) begin : g_idx_multi
            assign req_idx  = req.pc[OFF+IDX_BITS-1:OFF];
            assign miss_idx = miss_line[IDX_BITS-1:0];
        end else begin : g_idx_single
            assign req_idx  = '0;
            assign miss_idx = '0;
        end
    endgenerate

    assign req_tag        = req.pc[XLEN-1:OFF+IDX_BITS];
    assign req_word       = req.pc[OFF-1:2];
    assign miss_tag       = miss_line[LINE_W-1:IDX_BITS];
    assign unused_pc_bits = ^req.pc[1:0];

    always_comb begin
        hit_vec = '0;
        hit_way = '0;
        for (int w = 0; w < WAYS_NUM; w++) begin
            hit_vec[w] = valid_q[req_idx][w] && (tag_q[req_idx][w] == req_tag);
            if (hit_vec[w]) hit_way = WAY_W'(w);
        end
    end

    // Invalid ways take priority over the PLRU choice; descending scan leaves the lowest one.
    always_comb begin
        fill_way = plru_victim;
        for (int w = WAYS_NUM - 1; w >= 0; w--) begin
            if (!valid_q[miss_idx][w]) fill_way = WAY_W'(w);
        end
    end

    assign lookup      = req.valid && (state == S_IDLE);
    assign lookup_hit  = lookup && (|hit_vec);
    assign lookup_miss = lookup && !(|hit_vec);
    assign fill        = (state == S_WAIT) && bus.mem_rsp_valid;
    assign hit_line    = data_q[req_idx][hit_way];

    // Hits only happen in IDLE and fills only in WAIT, so one PLRU helper serves both.
    assign plru_set = (state == S_WAIT) ? miss_idx : req_idx;
    assign plru_way = (state == S_WAIT) ? fill_way : hit_way;
    assign plru_en  = lookup_hit || fill;

    i_cache_plru #(.WAYS_NUM(WAYS_NUM)) u_plru (
        .cur_bits   (plru_q[plru_set]),
        .access_way (plru_way),
        .update_en  (plru_en),
        .next_bits  (plru_next),
        .victim_way (plru_victim)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (lookup_miss)        state_next = S_REQ;
            S_REQ:   if (bus.mem_req_ready)  state_next = S_WAIT;
            S_WAIT:  if (bus.mem_rsp_valid)  state_next = S_IDLE;
            default:                         state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SETS_NUM; s++) begin
                valid_q[s] <= '0;
                plru_q[s]  <= '0;
            end
            miss_line  <= '0;
            miss_word  <= '0;
            rsp_q      <= '0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            rsp_q.valid <= 1'b0;
            if (lookup_hit) begin
                rsp_q.valid       <= 1'b1;
                rsp_q.instruction <= hit_line[{req_word, 5'b0} +: 32];
                if (!(&hit_cnt_q)) hit_cnt_q <= hit_cnt_q + CNT_ONE;
            end
            if (lookup_miss) begin
                miss_line <= req.pc[XLEN-1:OFF];
                miss_word <= req_word;
                if (!(&miss_cnt_q)) miss_cnt_q <= miss_cnt_q + CNT_ONE;
            end
            if (fill) begin
                valid_q[miss_idx][fill_way] <= 1'b1;
                rsp_q.valid                 <= 1'b1;
                rsp_q.instruction           <= bus.mem_rsp_data[{miss_word, 5'b0} +: 32];
            end
            if (plru_en) plru_q[plru_set] <= plru_next;
            // Placed last so a flush overrides the valid bit set by a same-cycle fill.
            if (bus.flush) begin
                for (int s = 0; s < SETS_NUM; s++) valid_q[s] <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (fill && !rst) begin
            data_q[miss_idx][fill_way] <= bus.mem_rsp_data;
            tag_q[miss_idx][fill_way]  <= miss_tag;
        end
    end

    assign bus.cache2core_rsp_valid       = rsp_q.valid;
    assign bus.cache2core_rsp_instruction = rsp_q.instruction;
    assign bus.cache_stall                = (state != S_IDLE);
    assign bus.mem_req_valid              = (state == S_REQ);
    assign bus.mem_req_addr               = {miss_line, {OFF{1'b0}}};
    assign bus.hit_cnt                    = hit_cnt_q;
    assign bus.miss_cnt                   = miss_cnt_q;
endmodule
`default_nettype wire

// File: tb/tb_i_cache_sa.sv
`default_nettype none
// ============================================================================
// tb_i_cache_sa : randomized self-checking bench with a behavioural cache model
// Rev 1.0
// ============================================================================
module tb_i_cache_sa;
    localparam int CNTW = 4;
    localparam int CMAX = 15;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    i_cache_sa_if #(.CL_WIDTH(128), .CNT_WIDTH(CNTW)) bus ();

    i_cache_sa #(.WAYS_NUM(4), .SETS_NUM(16), .CL_WIDTH(128), .CNT_WIDTH(CNTW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Behavioural model: per-way contents plus last-access timestamps for pseudo-LRU
    logic [127:0] m_data  [16][4];
    logic [23:0]  m_tag   [16][4];
    bit           m_valid [16][4];
    longint       m_ts    [16][4];
    longint       m_time;
    int           m_hits, m_misses;

    function automatic void m_clear();
        for (int s = 0; s < 16; s++)
            for (int w = 0; w < 4; w++) begin
                m_valid[s][w] = 0;
                m_ts[s][w]    = 0;
            end
        m_time = 0; m_hits = 0; m_misses = 0;
    endfunction

    function automatic void m_flush();
        for (int s = 0; s < 16; s++)
            for (int w = 0; w < 4; w++) m_valid[s][w] = 0;
    endfunction

    function automatic int m_lookup(input logic [31:0] pc);
        int r = -1;
        for (int w = 0; w < 4; w++)
            if (m_valid[pc[7:4]][w] && m_tag[pc[7:4]][w] == pc[31:8]) r = w;
        return r;
    endfunction

    function automatic void m_touch(input int s, input int w);
        m_time++;
        m_ts[s][w] = m_time;
    endfunction

    // Tree PLRU seen from the outside: at each level evict from the half whose most recent access is older.
    function automatic int m_victim(input int s);
        int lo, n, half;
        longint ml, mr;
        for (int w = 0; w < 4; w++) if (!m_valid[s][w]) return w;
        lo = 0; n = 4;
        while (n > 1) begin
            half = n / 2; ml = 0; mr = 0;
            for (int w = 0; w < half; w++) begin
                if (m_ts[s][lo+w] > ml)      ml = m_ts[s][lo+w];
                if (m_ts[s][lo+half+w] > mr) mr = m_ts[s][lo+half+w];
            end
            if (ml > mr) lo = lo + half;
            n = half;
        end
        return lo;
    endfunction

    function automatic int sat(input int v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    task automatic cycle();
        @(posedge clk); #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        bus.core_req_valid = 0; bus.pcQ100H = 0; bus.flush = 0;
        bus.mem_req_ready = 0; bus.mem_rsp_valid = 0; bus.mem_rsp_data = '0;
        cycle(); cycle();
        rst = 1'b0;
        m_clear();
    endtask

    // flush_mode: 0 none, 1 flush with the request, 2 flush with the refill data
    task automatic do_fetch(input logic [31:0] pc, input int rdy_dly, input int rsp_dly,
                            input logic [127:0] line, input int flush_mode);
        int s, way, wsel, v;
        logic exp_hit;
        logic [31:0] exp_instr, line_addr;
        s = int'(pc[7:4]); wsel = int'(pc[3:2]); line_addr = {pc[31:4], 4'b0};
        way = m_lookup(pc); exp_hit = (way >= 0); exp_instr = '0;
        bus.core_req_valid = 1; bus.pcQ100H = pc; bus.flush = (flush_mode == 1);
        cycle();
        bus.core_req_valid = 0; bus.flush = 0;
        if (exp_hit) begin
            exp_instr = m_data[s][way][wsel*32 +: 32];
            m_touch(s, way); m_hits++;
        end else m_misses++;
        if (flush_mode == 1) m_flush();
        tests++;
        if (bus.cache2core_rsp_valid !== exp_hit) begin
            fails++; $display("FAIL fetch_hit pc=%h got rsp_valid=%0b exp %0b", pc, bus.cache2core_rsp_valid, exp_hit);
        end
        tests++;
        if (bus.cache_stall !== !exp_hit) begin
            fails++; $display("FAIL fetch_stall pc=%h got %0b exp %0b", pc, bus.cache_stall, !exp_hit);
        end
        if (exp_hit) begin
            tests++;
            if (bus.cache2core_rsp_instruction !== exp_instr) begin
                fails++; $display("FAIL hit_instr pc=%h got %h exp %h", pc, bus.cache2core_rsp_instruction, exp_instr);
            end
        end
        if (bus.cache_stall === 1'b1) begin
            tests++;
            if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== line_addr) begin
                fails++; $display("FAIL req_issue pc=%h got valid=%0b addr=%h exp 1 %h", pc, bus.mem_req_valid, bus.mem_req_addr, line_addr);
            end
            for (int i = 0; i < rdy_dly; i++) begin
                bus.core_req_valid = 1; bus.pcQ100H = $urandom;
                cycle();
                tests++;
                if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== line_addr || bus.cache_stall !== 1'b1) begin
                    fails++; $display("FAIL req_hold got valid=%0b addr=%h stall=%0b exp 1 %h 1", bus.mem_req_valid, bus.mem_req_addr, bus.cache_stall, line_addr);
                end
            end
            bus.core_req_valid = 0;
            bus.mem_req_ready = 1;
            cycle();
            bus.mem_req_ready = 0;
            tests++;
            if (bus.mem_req_valid !== 1'b0 || bus.cache_stall !== 1'b1) begin
                fails++; $display("FAIL req_accept got valid=%0b stall=%0b exp 0 1", bus.mem_req_valid, bus.cache_stall);
            end
            for (int i = 0; i < rsp_dly; i++) begin
                cycle();
                tests++;
                if (bus.cache_stall !== 1'b1 || bus.cache2core_rsp_valid !== 1'b0) begin
                    fails++; $display("FAIL wait_hold got stall=%0b rsp=%0b exp 1 0", bus.cache_stall, bus.cache2core_rsp_valid);
                end
            end
            bus.mem_rsp_valid = 1; bus.mem_rsp_data = line; bus.flush = (flush_mode == 2);
            cycle();
            bus.mem_rsp_valid = 0; bus.flush = 0;
            if (!exp_hit) begin
                v = m_victim(s);
                m_data[s][v] = line; m_tag[s][v] = pc[31:8]; m_valid[s][v] = 1;
                m_touch(s, v);
                exp_instr = line[wsel*32 +: 32];
            end
            if (flush_mode == 2) m_flush();
            tests++;
            if (bus.cache2core_rsp_valid !== 1'b1 || bus.cache_stall !== 1'b0 || bus.cache2core_rsp_instruction !== exp_instr) begin
                fails++; $display("FAIL refill_rsp pc=%h got v=%0b stall=%0b instr=%h exp 1 0 %h", pc, bus.cache2core_rsp_valid, bus.cache_stall, bus.cache2core_rsp_instruction, exp_instr);
            end
        end
        tests++;
        if (bus.hit_cnt !== CNTW'(sat(m_hits)) || bus.miss_cnt !== CNTW'(sat(m_misses))) begin
            fails++; $display("FAIL counters got hit=%0d miss=%0d exp %0d %0d", bus.hit_cnt, bus.miss_cnt, sat(m_hits), sat(m_misses));
        end
    endtask

    function automatic logic [127:0] rnd_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic test_reset();
        apply_reset();
        tests++;
        if ({bus.cache2core_rsp_valid, bus.cache_stall, bus.mem_req_valid} !== 3'b000) begin
            fails++; $display("FAIL reset_flags got %b exp 000", {bus.cache2core_rsp_valid, bus.cache_stall, bus.mem_req_valid});
        end
        tests++;
        if (bus.cache2core_rsp_instruction !== 32'h0 || bus.mem_req_addr !== 32'h0) begin
            fails++; $display("FAIL reset_data got instr=%h addr=%h exp 0 0", bus.cache2core_rsp_instruction, bus.mem_req_addr);
        end
        tests++;
        if (bus.hit_cnt !== '0 || bus.miss_cnt !== '0) begin
            fails++; $display("FAIL reset_cnt got %0d %0d exp 0 0", bus.hit_cnt, bus.miss_cnt);
        end
    endtask

    task automatic test_cold_miss();
        logic [127:0] line;
        apply_reset();
        line = {32'h33333333, 32'h22222222, 32'hDEADBEEF, 32'h11111111};
        do_fetch(32'h100, 0, 0, line, 0);
        do_fetch(32'h104, 0, 0, line, 0);
        tests++;
        if (bus.cache2core_rsp_instruction !== 32'hDEADBEEF || bus.hit_cnt !== 4'd1 || bus.miss_cnt !== 4'd1) begin
            fails++; $display("FAIL cold_miss got instr=%h hit=%0d miss=%0d exp deadbeef 1 1", bus.cache2core_rsp_instruction, bus.hit_cnt, bus.miss_cnt);
        end
    endtask

    task automatic test_stalled_handshake();
        apply_reset();
        do_fetch(32'h0000_0A40, 5, 2, rnd_line(), 0);
        do_fetch(32'h0000_0A48, 0, 0, rnd_line(), 0);
    endtask

    task automatic test_replacement();
        apply_reset();
        for (int t = 1; t <= 4; t++) do_fetch(32'(t) << 12, 0, 0, rnd_line(), 0);
        do_fetch(32'h1000, 0, 0, rnd_line(), 0);
        do_fetch(32'h2004, 0, 0, rnd_line(), 0);
        do_fetch(32'h5008, 1, 1, rnd_line(), 0);
        do_fetch(32'h1000, 0, 0, rnd_line(), 0);
        do_fetch(32'h2000, 0, 0, rnd_line(), 0);
        do_fetch(32'h4000, 0, 0, rnd_line(), 0);
        tests++;
        if (bus.cache_stall !== 1'b0 || bus.miss_cnt !== 4'd5) begin
            fails++; $display("FAIL replace_keep got stall=%0b miss=%0d exp 0 5", bus.cache_stall, bus.miss_cnt);
        end
        do_fetch(32'h3000, 0, 0, rnd_line(), 0);
        tests++;
        if (bus.miss_cnt !== 4'd6) begin
            fails++; $display("FAIL replace_evict got miss=%0d exp 6", bus.miss_cnt);
        end
    endtask

    task automatic test_flush();
        apply_reset();
        do_fetch(32'h200, 0, 0, rnd_line(), 0);
        do_fetch(32'h200, 0, 0, rnd_line(), 1);
        tests++;
        if (bus.hit_cnt !== 4'd1) begin
            fails++; $display("FAIL flush_lookup got hit=%0d exp 1", bus.hit_cnt);
        end
        do_fetch(32'h200, 0, 0, rnd_line(), 0);
        do_fetch(32'h210, 1, 1, rnd_line(), 2);
        do_fetch(32'h210, 0, 0, rnd_line(), 0);
        tests++;
        if (bus.miss_cnt !== 4'd4) begin
            fails++; $display("FAIL flush_fill got miss=%0d exp 4", bus.miss_cnt);
        end
    endtask

    task automatic test_reset_mid_miss();
        apply_reset();
        bus.core_req_valid = 1; bus.pcQ100H = 32'h440;
        cycle();
        bus.core_req_valid = 0; bus.mem_req_ready = 1;
        cycle();
        bus.mem_req_ready = 0; rst = 1;
        cycle();
        rst = 0;
        bus.mem_rsp_valid = 1; bus.mem_rsp_data = rnd_line();
        cycle();
        bus.mem_rsp_valid = 0;
        m_clear();
        tests++;
        if ({bus.cache2core_rsp_valid, bus.cache_stall, bus.mem_req_valid} !== 3'b000 || bus.cache2core_rsp_instruction !== 32'h0) begin
            fails++; $display("FAIL rst_wait got flags=%b instr=%h exp 000 0", {bus.cache2core_rsp_valid, bus.cache_stall, bus.mem_req_valid}, bus.cache2core_rsp_instruction);
        end
        tests++;
        if (bus.hit_cnt !== '0 || bus.miss_cnt !== '0) begin
            fails++; $display("FAIL rst_wait_cnt got %0d %0d exp 0 0", bus.hit_cnt, bus.miss_cnt);
        end
        do_fetch(32'h440, 0, 0, rnd_line(), 0);
        bus.core_req_valid = 1; bus.pcQ100H = 32'h480;
        cycle();
        bus.core_req_valid = 0; rst = 1;
        cycle();
        rst = 0;
        m_clear();
        tests++;
        if (bus.mem_req_valid !== 1'b0 || bus.cache_stall !== 1'b0) begin
            fails++; $display("FAIL rst_req got valid=%0b stall=%0b exp 0 0", bus.mem_req_valid, bus.cache_stall);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] pc, exp_instr;
        int s, w;
        apply_reset();
        for (int i = 0; i < 4; i++) do_fetch(32'h300 + 32'(i * 16), 0, 0, rnd_line(), 0);
        for (int k = 0; k < 12; k++) begin
            pc = 32'h300 + 32'($urandom_range(0, 3) * 16) + 32'($urandom_range(0, 15));
            s = int'(pc[7:4]); w = m_lookup(pc);
            exp_instr = (w >= 0) ? m_data[s][w][int'(pc[3:2])*32 +: 32] : 32'h0;
            if (w >= 0) begin m_touch(s, w); m_hits++; end
            bus.core_req_valid = 1; bus.pcQ100H = pc;
            cycle();
            tests++;
            if (bus.cache2core_rsp_valid !== 1'b1 || bus.cache2core_rsp_instruction !== exp_instr) begin
                fails++; $display("FAIL b2b k=%0d got v=%0b instr=%h exp 1 %h", k, bus.cache2core_rsp_valid, bus.cache2core_rsp_instruction, exp_instr);
            end
        end
        bus.core_req_valid = 0;
        cycle();
        tests++;
        if (bus.cache2core_rsp_valid !== 1'b0 || bus.hit_cnt !== CNTW'(sat(m_hits))) begin
            fails++; $display("FAIL b2b_end got v=%0b hit=%0d exp 0 %0d", bus.cache2core_rsp_valid, bus.hit_cnt, sat(m_hits));
        end
    endtask

    task automatic test_saturation();
        apply_reset();
        do_fetch(32'h600, 0, 0, rnd_line(), 0);
        for (int i = 0; i < 20; i++) do_fetch(32'h600 + 32'((i % 4) * 4), 0, 0, rnd_line(), 0);
        tests++;
        if (bus.hit_cnt !== 4'hF || bus.miss_cnt !== 4'd1) begin
            fails++; $display("FAIL saturation got hit=%h miss=%0d exp f 1", bus.hit_cnt, bus.miss_cnt);
        end
    endtask

    task automatic test_random();
        logic [31:0] pc;
        int r, mode;
        apply_reset();
        for (int n = 0; n < 250; n++) begin
            pc = (32'($urandom_range(1, 6)) << 8) | (32'($urandom_range(0, 1)) << 4) | 32'($urandom_range(0, 15));
            r = $urandom_range(0, 19);
            mode = (r == 0) ? 1 : (r == 1) ? 2 : 0;
            do_fetch(pc, $urandom_range(0, 3), $urandom_range(0, 3), rnd_line(), mode);
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_cold_miss();
        test_stalled_handshake();
        test_replacement();
        test_flush();
        test_reset_mid_miss();
        test_back_to_back();
        test_saturation();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
`default_nettype wire
